// File: rtl/fu_result_collector_pkg.sv
// Shared types for the FU result collector: result bundle, exception
// record and width helpers for the collector and its arbiter.
package fu_result_collector_pkg;

  localparam int unsigned XLEN          = 64;
  localparam int unsigned TRANS_ID_BITS = 3;
  localparam int unsigned NR_FU_DEFAULT = 4;
  localparam int unsigned DEPTH_DEFAULT = 4;

  localparam logic [XLEN-1:0] INSTR_ADDR_MISALIGNED = 64'd0;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
  } exception_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] index;
    logic [4:0]               rd;
    logic [XLEN-1:0]          result;
    exception_t               ex;
  } fu_result_t;

  function automatic int unsigned cnt_width(
    input int unsigned depth
  );
    return $clog2(depth) + 1;
  endfunction

  function automatic int unsigned idx_width(
    input int unsigned n
  );
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fu_result_collector_rr_arbiter.sv
// Round-robin grant: first requester at or above ptr_i, wrapping to 0.
// Purely combinational; the caller owns and advances the pointer.
module fu_result_collector_rr_arbiter
  import fu_result_collector_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned PW = idx_width(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);

  logic [PW-1:0] j;

  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    j       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = PW'((32'(ptr_i) + k) % N);
      if (!valid_o && req_i[j]) begin
        valid_o  = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = j;
      end
    end
  end

endmodule

// File: rtl/fu_result_collector.sv
// Collects FU results (round-robin, one per cycle) into an in-order FIFO.
// TORTOISE_WB_BYPASS_EN: present a result on wb_* the cycle it is granted.
module fu_result_collector
  import fu_result_collector_pkg::*;
#(
  parameter  int unsigned NR_FU = NR_FU_DEFAULT,
  parameter  int unsigned DEPTH = DEPTH_DEFAULT,
  localparam int unsigned CW    = cnt_width(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic [NR_FU-1:0] fu_result_valid_i,
  output logic [NR_FU-1:0] fu_result_ready_o,
  input  fu_result_t       fu_result_i [NR_FU],
  output logic             wb_valid_o,
  input  logic             wb_ready_i,
  output fu_result_t       wb_result_o,
  output logic [CW-1:0]    count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = idx_width(NR_FU);

  fu_result_t    mem_q [DEPTH];
  fu_result_t    mem_d [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;

  logic [NR_FU-1:0] grant;
  logic [PW-1:0]    gnt_idx;
  logic             gnt_valid;
  fu_result_t       gnt_data;

  logic full;
  logic fifo_valid;
  logic pop;
  logic can_push;
  logic push;
  logic write_en;

  fu_result_collector_rr_arbiter #(
    .N  (NR_FU),
    .PW (PW)
  ) u_arb (
    .req_i   (fu_result_valid_i),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (grant),
    .idx_o   (gnt_idx),
    .valid_o (gnt_valid)
  );

  assign full       = (count_q == CW'(DEPTH));
  assign fifo_valid = (count_q != '0);
  assign pop        = fifo_valid & wb_ready_i;
  // Room exists when not full, or when the head leaves this same cycle.
  assign can_push   = (~full | pop) & ~flush_i & ~rst_i;
  assign push       = gnt_valid & can_push;
  assign gnt_data   = fu_result_i[gnt_idx];

  assign fu_result_ready_o = grant & {NR_FU{can_push}};
  assign count_o           = count_q;

`ifdef TORTOISE_WB_BYPASS_EN
  logic bypass;

  assign bypass      = push & ~fifo_valid;
  assign wb_valid_o  = fifo_valid | bypass;
  assign wb_result_o = fifo_valid ? mem_q[rd_ptr_q] : gnt_data;
  assign write_en    = push & ~(bypass & wb_ready_i);
`else
  assign wb_valid_o  = fifo_valid;
  assign wb_result_o = mem_q[rd_ptr_q];
  assign write_en    = push;
`endif

  always_comb begin
    mem_d    = mem_q;
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    rr_ptr_d = rr_ptr_q;
    if (write_en) begin
      mem_d[wr_ptr_q] = gnt_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({write_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push) begin
      rr_ptr_d = (gnt_idx == PW'(NR_FU - 1)) ? '0 : gnt_idx + 1'b1;
    end
    if (flush_i) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_fu_result_collector.sv
// Scoreboard bench for fu_result_collector: a queue model of the FIFO
// predicts grants and in-order writeback under random traffic.
module tb_fu_result_collector;
  import fu_result_collector_pkg::*;

  localparam int NR_FU = 4;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [NR_FU-1:0] fu_valid;
  logic [NR_FU-1:0] fu_ready;
  fu_result_t       fu_data [NR_FU];
  logic             wb_valid;
  logic             wb_ready;
  fu_result_t       wb_result;
  logic [CW-1:0]    count;

  int checks   = 0;
  int failures = 0;

  fu_result_t exp_q [$];
  int         m_rr = 0;

  always #5 clk = ~clk;

  fu_result_collector #(
    .NR_FU (NR_FU),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .flush_i           (flush),
    .fu_result_valid_i (fu_valid),
    .fu_result_ready_o (fu_ready),
    .fu_result_i       (fu_data),
    .wb_valid_o        (wb_valid),
    .wb_ready_i        (wb_ready),
    .wb_result_o       (wb_result),
    .count_o           (count)
  );

  task automatic chk(input string name, input logic [255:0] act,
                     input logic [255:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic fu_result_t rand_res();
    fu_result_t r;
    r.index    = 3'($urandom);
    r.rd       = 5'($urandom);
    r.result   = {$urandom, $urandom};
    r.ex.valid = 1'($urandom);
    r.ex.cause = 64'($urandom_range(15));
    r.ex.tval  = {$urandom, $urandom};
    return r;
  endfunction

  // Monitor: compares what the DUT presents against the expected queue.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_wb_valid", 256'(wb_valid), 256'(0));
      chk("rst_ready", 256'(fu_ready), 256'(0));
      chk("rst_count", 256'(count), 256'(0));
    end else begin
      chk("count", 256'(count), 256'(exp_q.size()));
      chk("wb_valid", 256'(wb_valid), 256'(exp_q.size() != 0));
      if (wb_valid && exp_q.size() != 0) begin
        chk("wb_result", 256'(wb_result), 256'(exp_q[0]));
        if (wb_ready) void'(exp_q.pop_front());
      end
    end
  end

  // Reference: predicts the grant and records accepted results in order.
  always @(negedge clk) begin
    int               g;
    logic [NR_FU-1:0] eg;
    bit               room;
    #1;
    if (rst) begin
      exp_q.delete();
      m_rr = 0;
    end else begin
      room = !flush && exp_q.size() < DEPTH;
      g = -1;
      for (int k = 0; k < NR_FU; k++) begin
        int j;
        j = (m_rr + k) % NR_FU;
        if (g < 0 && fu_valid[j]) g = j;
      end
      eg = '0;
      if (room && g >= 0) eg = 4'(1 << g);
      chk("ready", 256'(fu_ready), 256'(eg));
      if (flush) exp_q.delete();
      else if (eg != '0) begin
        exp_q.push_back(fu_data[g]);
        m_rr = (g + 1) % NR_FU;
      end
    end
  end

  task automatic step(input int vp, input int rp, input int fp);
    logic [NR_FU-1:0] took;
    @(negedge clk);
    took = fu_valid & fu_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < NR_FU; i++) begin
      if (took[i]) fu_valid[i] = 1'b0;
      if (!fu_valid[i] && $urandom_range(99) < vp) begin
        fu_valid[i] = 1'b1;
        fu_data[i]  = rand_res();
      end
    end
    wb_ready = ($urandom_range(99) < rp);
    flush    = ($urandom_range(99) < fp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    fu_result_t t;
    rst      = 1'b1;
    flush    = 1'b0;
    wb_ready = 1'b0;
    fu_valid = '0;
    for (int i = 0; i < NR_FU; i++) fu_data[i] = '0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;

    // single ALU result, one-cycle latency
    step(0, 100, 0);
    t        = '0;
    t.index  = 3'd3;
    t.rd     = 5'd5;
    t.result = 64'h1234;
    fu_valid[0] = 1'b1;
    fu_data[0]  = t;
    repeat (3) step(0, 100, 0);
    chk("t1_count", 256'(count), 256'(0));

    // all FUs streaming
    repeat (10) step(100, 100, 0);

    // fill with consumer stalled, then push+pop at full
    repeat (6) step(100, 0, 0);
    chk("t3_full", 256'(count), 256'(4));
    chk("t3_ready", 256'(fu_ready), 256'(0));
    repeat (4) step(100, 100, 0);
    chk("t3_stay", 256'(count), 256'(4));

    // flush at count 3 with FU1 valid
    fu_valid = '0;
    wb_ready = 1'b1;
    @(posedge clk);
    #1;
    wb_ready = 1'b0;
    chk("t4_pre", 256'(count), 256'(3));
    fu_valid[1] = 1'b1;
    fu_data[1]  = rand_res();
    flush       = 1'b1;
    #1 chk("t4_ready", 256'(fu_ready), 256'(0));
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("t4_count", 256'(count), 256'(0));
    chk("t4_wb_valid", 256'(wb_valid), 256'(0));

    // JAL_R exception forwarded bit-exact
    t          = rand_res();
    t.ex.valid = 1'b1;
    t.ex.cause = INSTR_ADDR_MISALIGNED;
    t.ex.tval  = 64'h8000_0004;
    fu_valid[2] = 1'b1;
    fu_data[2]  = t;
    repeat (5) step(0, 100, 0);

    // async reset mid-stream at count 2
    fu_valid = '0;
    wb_ready = 1'b0;
    fu_valid[0] = 1'b1;
    fu_data[0]  = rand_res();
    fu_valid[3] = 1'b1;
    fu_data[3]  = rand_res();
    repeat (2) step(0, 0, 0);
    chk("t6_pre", 256'(count), 256'(2));
    #2 rst = 1'b1;
    #1;
    chk("t6_wb_valid", 256'(wb_valid), 256'(0));
    chk("t6_ready", 256'(fu_ready), 256'(0));
    chk("t6_count", 256'(count), 256'(0));
    for (int i = 0; i < NR_FU; i++) begin
      fu_valid[i] = 1'b1;
      fu_data[i]  = rand_res();
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    repeat (6) step(100, 100, 0);

    // random traffic
    repeat (400) step($urandom_range(100), $urandom_range(100), 5);

    // drain
    fu_valid = '0;
    flush    = 1'b0;
    repeat (8) step(0, 100, 0);
    chk("drain_count", 256'(count), 256'(0));
    chk("drain_wb_valid", 256'(wb_valid), 256'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
